demux_route_ctrl_v: RTL and testbench

- Upstream controller for the 1-to-4 one-hot demultiplexer stage.
- Accepts (data bit, 2-bit destination) items over a valid/ready handshake and buffers them in a small FIFO.
- Drives the demux data input `o_a` and one-hot select `o_sel_code` for a fixed number of cycles per item, with an optional all-zero gap between items.
- Output ports connect directly to the demux `i_a` / `i_sel_code` inputs.

---
 rtl/demux_route_ctrl_v.sv | 163 ++++++++++++++++
 tb/tb_demux_route_ctrl_v.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_route_ctrl_v.sv
// rtl/demux_route_ctrl_v.sv - FIFO-buffered hold/gap sequencer driving a 1-to-4 one-hot demux; flush port under DEMUX_ROUTE_CTRL_FLUSH_EN
module demux_route_ctrl_v #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_data,
    input  logic [1:0]                  i_dest,
`ifdef DEMUX_ROUTE_CTRL_FLUSH_EN
    input  logic                        i_flush,
`endif
    output logic                        o_a,
    output logic [3:0]                  o_sel_code,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

    state_t          state, state_d;
    logic [2:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [GW-1:0]   gap_cnt, gap_d;
    logic            a_d, busy_d, load, push, pop, flush;
    logic [3:0]      sel_d;
    logic [2:0]      head;

`ifdef DEMUX_ROUTE_CTRL_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign o_ready = (count < FULL);
    assign o_count = count;
    assign push    = i_valid && o_ready && !flush;
    assign pop     = load;
    assign head    = mem[rd_ptr];

    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        gap_d   = gap_cnt;
        a_d     = o_a;
        sel_d   = o_sel_code;
        busy_d  = o_busy;
        load    = 1'b0;
        case (state)
            ST_IDLE: begin
                a_d    = 1'b0;
                sel_d  = 4'b0000;
                busy_d = 1'b0;
                if (count != '0) begin
                    load    = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (hold_cnt != '0) begin
                    hold_d = hold_cnt - HW'(1);
                end else if (GAP_CYCLES > 0) begin
                    a_d     = 1'b0;
                    sel_d   = 4'b0000;
                    gap_d   = GW'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else if (count != '0) begin
                    load = 1'b1;
                end else begin
                    a_d     = 1'b0;
                    sel_d   = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                a_d   = 1'b0;
                sel_d = 4'b0000;
                if (gap_cnt != '0) begin
                    gap_d = gap_cnt - GW'(1);
                end else if (count != '0) begin
                    load    = 1'b1;
                    state_d = ST_DRIVE;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                a_d     = 1'b0;
                sel_d   = 4'b0000;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // Loading the head item overrides whatever the state branch chose
        if (load) begin
            a_d    = head[2];
            sel_d  = 4'b0001 << head[1:0];
            hold_d = HW'(HOLD_CYCLES - 1);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_data, i_dest};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            o_a        <= 1'b0;
            o_sel_code <= 4'b0000;
            o_busy     <= 1'b0;
        end else if (flush) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            o_a        <= 1'b0;
            o_sel_code <= 4'b0000;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_d;
            hold_cnt   <= hold_d;
            gap_cnt    <= gap_d;
            o_a        <= a_d;
            o_sel_code <= sel_d;
            o_busy     <= busy_d;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_route_ctrl_v.sv
// tb/tb_demux_route_ctrl_v.sv - scoreboard bench for demux_route_ctrl_v (default and hold=1/gap=0 instances)
module tb_demux_route_ctrl_v;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a = 1'b0, data_a = 1'b0, flush_a = 1'b0;
    logic [1:0] dest_a = 2'd0;
    logic       ready_a, a_a, busy_a;
    logic [3:0] sel_a;
    logic [2:0] count_a;
    logic       valid_b = 1'b0, data_b = 1'b0, flush_b = 1'b0;
    logic [1:0] dest_b = 2'd0;
    logic       ready_b, a_b, busy_b;
    logic [3:0] sel_b;
    logic [2:0] count_b;

    int         total = 0;
    int         passed = 0;
    logic [2:0] sb_a [$];
    logic [2:0] sb_b [$];
    logic [3:0] prev_sel = 4'd0;
    logic       prev_a = 1'b0;
    int         run_len = 0;
    logic [2:0] mon_item;

    always #5 clk = ~clk;

    demux_route_ctrl_v #(.FIFO_DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .o_ready(ready_a),
        .i_data(data_a), .i_dest(dest_a),
`ifdef DEMUX_ROUTE_CTRL_FLUSH_EN
        .i_flush(flush_a),
`endif
        .o_a(a_a), .o_sel_code(sel_a), .o_busy(busy_a), .o_count(count_a)
    );

    demux_route_ctrl_v #(.FIFO_DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .o_ready(ready_b),
        .i_data(data_b), .i_dest(dest_b),
`ifdef DEMUX_ROUTE_CTRL_FLUSH_EN
        .i_flush(flush_b),
`endif
        .o_a(a_b), .o_sel_code(sel_b), .o_busy(busy_b), .o_count(count_b)
    );

    // Output monitor for dut_a: pops the scoreboard at each item start, checks hold length
    always @(negedge clk) begin
        if (rst || flush_a) begin
            prev_sel = 4'd0;
            run_len  = 0;
        end else begin
            total++;
            if ((sel_a & (sel_a - 4'd1)) !== 4'd0) $display("FAIL onehot: sel=%b", sel_a);
            else passed++;
            total++;
            if (ready_a !== (count_a < 3'd4)) $display("FAIL ready_vs_count: ready=%b count=%0d", ready_a, count_a);
            else passed++;
            if (sel_a != 4'd0 && prev_sel == 4'd0) begin
                total++;
                if (sb_a.size() == 0) begin
                    $display("FAIL unexpected_item: a=%b sel=%b, scoreboard empty", a_a, sel_a);
                end else begin
                    mon_item = sb_a.pop_front();
                    if ({a_a, sel_a} !== {mon_item[2], 4'b0001 << mon_item[1:0]})
                        $display("FAIL item_order: got a=%b sel=%b expected a=%b dest=%0d", a_a, sel_a, mon_item[2], mon_item[1:0]);
                    else passed++;
                end
                run_len = 1;
            end else if (sel_a != 4'd0) begin
                total++;
                if (sel_a !== prev_sel || a_a !== prev_a)
                    $display("FAIL hold_stable: got a=%b sel=%b expected a=%b sel=%b", a_a, sel_a, prev_a, prev_sel);
                else passed++;
                run_len++;
            end else if (prev_sel != 4'd0) begin
                total++;
                if (run_len !== 2) $display("FAIL hold_len: got %0d expected 2", run_len);
                else passed++;
                run_len = 0;
            end
            prev_sel = sel_a;
            prev_a   = a_a;
        end
    end

    task automatic push_a(input logic d, input logic [1:0] dst);
        bit acc = 1'b0;
        valid_a = 1'b1; data_a = d; dest_a = dst;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (ready_a) begin
                sb_a.push_back({d, dst});
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        valid_a = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL push_a_timeout: ready=%b expected 1 within 100 cycles", ready_a);
        end
    endtask

    task automatic push_b(input logic d, input logic [1:0] dst);
        bit acc = 1'b0;
        valid_b = 1'b1; data_b = d; dest_b = dst;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (ready_b) begin
                sb_b.push_back({d, dst});
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        valid_b = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL push_b_timeout: ready=%b expected 1 within 100 cycles", ready_b);
        end
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 100; i++) begin
            if (!busy_a && count_a == 3'd0) break;
            @(posedge clk); #1;
        end
        total++;
        if (busy_a !== 1'b0 || count_a !== 3'd0) $display("FAIL idle_timeout: busy=%b count=%0d expected 0/0", busy_a, count_a);
        else passed++;
        total++;
        if (sb_a.size() != 0) $display("FAIL items_lost: %0d undelivered expected 0", sb_a.size());
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a_a, sel_a, busy_a, count_a, ready_a} !== {1'b0, 4'd0, 1'b0, 3'd0, 1'b1})
            $display("FAIL reset_state: a=%b sel=%b busy=%b count=%0d ready=%b expected 0 0000 0 0 1", a_a, sel_a, busy_a, count_a, ready_a);
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({sel_a, busy_a, ready_a} !== {4'd0, 1'b0, 1'b1})
            $display("FAIL after_release: sel=%b busy=%b ready=%b expected 0000 0 1", sel_a, busy_a, ready_a);
        else passed++;
    endtask

    task automatic test_single();
        logic [3:0] es [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic       ea [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        push_a(1'b1, 2'd2);
        total++;
        if (sel_a !== 4'd0 || busy_a !== 1'b0) $display("FAIL single_latency: sel=%b busy=%b expected 0000 0", sel_a, busy_a);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++;
            if ({sel_a, a_a, busy_a} !== {es[k], ea[k], eb[k]})
                $display("FAIL single_cycle%0d: sel=%b a=%b busy=%b expected %b %b %b", k, sel_a, a_a, busy_a, es[k], ea[k], eb[k]);
            else passed++;
        end
        wait_idle_a();
    endtask

    task automatic test_back_to_back();
        logic [3:0] es [12] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
        logic       ea [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        fork
            begin
                push_a(1'b1, 2'd0);
                push_a(1'b0, 2'd1);
                push_a(1'b1, 2'd2);
                push_a(1'b1, 2'd3);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (sel_a != 4'd0) break;
                end
                if (sel_a == 4'd0) begin
                    total++;
                    $display("FAIL b2b_start_timeout: sel=%b expected nonzero", sel_a);
                end else begin
                    for (int k = 0; k < 12; k++) begin
                        if (k > 0) @(negedge clk);
                        total++;
                        if (sel_a !== es[k] || a_a !== ea[k])
                            $display("FAIL b2b_seq%0d: sel=%b a=%b expected %b %b", k, sel_a, a_a, es[k], ea[k]);
                        else passed++;
                    end
                end
            end
        join
        @(posedge clk); #1;
        wait_idle_a();
    endtask

    task automatic test_fill();
        push_a(1'b0, 2'd3);
        push_a(1'b1, 2'd1);
        push_a(1'b1, 2'd0);
        push_a(1'b0, 2'd2);
        push_a(1'b1, 2'd3);
        push_a(1'b0, 2'd1);
        total++;
        if (count_a !== 3'd4 || ready_a !== 1'b0) $display("FAIL fill_full: count=%0d ready=%b expected 4 0", count_a, ready_a);
        else passed++;
        push_a(1'b1, 2'd2);
        push_a(1'b0, 2'd0);
        wait_idle_a();
    endtask

    task automatic test_gap0();
        logic [2:0] it;
        fork
            begin
                push_b(1'b1, 2'd3);
                push_b(1'b0, 2'd0);
                push_b(1'b1, 2'd1);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (sel_b != 4'd0) break;
                end
                if (sel_b == 4'd0) begin
                    total++;
                    $display("FAIL gap0_start_timeout: sel=%b expected nonzero", sel_b);
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        if (k > 0) @(negedge clk);
                        total++;
                        if (sb_b.size() == 0) begin
                            $display("FAIL gap0_unexpected%0d: sel=%b scoreboard empty", k, sel_b);
                        end else begin
                            it = sb_b.pop_front();
                            if ({sel_b, a_b, busy_b} !== {4'b0001 << it[1:0], it[2], 1'b1})
                                $display("FAIL gap0_item%0d: sel=%b a=%b busy=%b expected dest=%0d a=%b busy=1", k, sel_b, a_b, busy_b, it[1:0], it[2]);
                            else passed++;
                        end
                    end
                    @(negedge clk);
                    total++;
                    if (sel_b !== 4'd0 || busy_b !== 1'b0) $display("FAIL gap0_end: sel=%b busy=%b expected 0000 0", sel_b, busy_b);
                    else passed++;
                end
            end
        join
        total++;
        if (sb_b.size() != 0) $display("FAIL gap0_lost: %0d undelivered expected 0", sb_b.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        push_a(1'b1, 2'd0);
        push_a(1'b0, 2'd1);
        push_a(1'b1, 2'd3);
        total++;
        if (busy_a !== 1'b1 || sel_a !== 4'b0001 || count_a !== 3'd2)
            $display("FAIL rstmid_pre: busy=%b sel=%b count=%0d expected 1 0001 2", busy_a, sel_a, count_a);
        else passed++;
        rst = 1'b1;
        sb_a.delete();
        #1;
        total++;
        if ({a_a, sel_a, busy_a, count_a} !== {1'b0, 4'd0, 1'b0, 3'd0})
            $display("FAIL rstmid_async: a=%b sel=%b busy=%b count=%0d expected 0 0000 0 0", a_a, sel_a, busy_a, count_a);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ready_a !== 1'b1 || count_a !== 3'd0 || sel_a !== 4'd0)
            $display("FAIL rstmid_release: ready=%b count=%0d sel=%b expected 1 0 0000", ready_a, count_a, sel_a);
        else passed++;
        push_a(1'b0, 2'd2);
        wait_idle_a();
    endtask

`ifdef DEMUX_ROUTE_CTRL_FLUSH_EN
    task automatic test_flush();
        push_a(1'b0, 2'd3);
        push_a(1'b1, 2'd2);
        push_a(1'b1, 2'd1);
        flush_a = 1'b1;
        sb_a.delete();
        @(posedge clk); #1;
        flush_a = 1'b0;
        total++;
        if ({sel_a, a_a, busy_a, count_a, ready_a} !== {4'd0, 1'b0, 1'b0, 3'd0, 1'b1})
            $display("FAIL flush_state: sel=%b a=%b busy=%b count=%0d ready=%b expected 0000 0 0 0 1", sel_a, a_a, busy_a, count_a, ready_a);
        else passed++;
        push_a(1'b1, 2'd0);
        wait_idle_a();
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_gap0();
        test_reset_mid();
`ifdef DEMUX_ROUTE_CTRL_FLUSH_EN
        test_flush();
`endif
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
